// File: rtl/onehot_rr_arbiter.sv
// Four-way round-robin arbiter with a registered one-hot grant and a hold limit.
// The grant register is self-checked for one-hot integrity (sticky err).
module onehot_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic       err
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic [3:0]       pick;
  logic [1:0]       idx;
  logic             own_req, at_max, release_now;

  assign own_req     = |(req & grant_q);
  assign at_max      = (cnt_q == CNT_W'(HOLD_MAX));
  assign release_now = !own_req || at_max;

  // Walk from the highest offset down so the bit nearest ptr is written last and wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = 0; i < 4; i++) begin
      if (ptr_q[i]) begin
        for (int off = 3; off >= 0; off--) begin
          idx = 2'(i + off);
          if (req[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= 4'b0001;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = OWN;
      OWN:     if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A drop on the limit cycle is a normal release, so timeout only fires while the owner still asks.
  always_comb begin
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          cnt_d   = CNT_W'(1);
        end
      end
      OWN: begin
        if (release_now) begin
          grant_d   = '0;
          ptr_d     = {grant_q[2:0], grant_q[3]};
          cnt_d     = '0;
          timeout_d = own_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: grant_d = '0;
    endcase
    err_d = err_q | (|(grant_q & (grant_q - 4'd1)));
  end

  always_comb begin
    grant   = grant_q;
    busy    = |grant_q;
    timeout = timeout_q;
    err     = err_q;
  end

endmodule
